monox_row_feeder: RTL and testbench

- Upstream sequencer for the monox automorphism stage.
- Reads one row per cycle from four parallel BRAM banks (lanes A, C, B, D, in data-slice order 0..3). Presents each row to the monox stage with a valid strobe, per-row negate flag, Galois exponent and start pulse.
- Waits for the downstream done level to rise before reporting its own completion to the controller.
- No backpressure exists downstream, so valid rows are issued back-to-back with no gaps.

---
 rtl/monox_row_feeder.sv | 132 +++++++++++++
 tb/tb_monox_row_feeder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/monox_row_feeder.sv
// rtl/monox_row_feeder.sv - issues BRAM rows back-to-back to the monox automorphism stage
// Optional MONOX_ROW_FEEDER_PERF_EN adds o_cycles, a saturating busy-cycle counter.
module monox_row_feeder #(
   parameter int DATA_WIDTH  = 64,
   parameter int INDEX_WIDTH = 13,
   parameter int ADDR_WIDTH  = INDEX_WIDTH - 1,
   parameter int RD_LATENCY  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_en,
   input  logic                      i_start,
   input  logic [INDEX_WIDTH-1:0]    i_len,
   input  logic [INDEX_WIDTH-1:0]    i_neg_from,
   input  logic                      i_neg_en,
   input  logic [3:0]                i_n,
   input  logic                      i_ds_done,
   output logic [4*ADDR_WIDTH-1:0]   o_rd_addr,
   output logic [3:0]                o_rd_en,
   input  logic [4*DATA_WIDTH-1:0]   i_rd_data,
   output logic [4*DATA_WIDTH-1:0]   o_data,
   output logic                      o_valid,
   output logic                      o_negate,
   output logic [3:0]                o_n,
   output logic                      o_start,
   output logic                      o_busy,
   output logic                      o_done
`ifdef MONOX_ROW_FEEDER_PERF_EN
   ,
   output logic [31:0]               o_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_DS} state_t;

   state_t                 state, state_nx;
   logic [INDEX_WIDTH-1:0] row, len_q, neg_from_q;
   logic                   neg_en_q;
   logic [3:0]             n_q;
   logic [2:0]             drain_cnt;
   logic [RD_LATENCY-1:0]  vld_line, neg_line;
   logic                   start_q;
   logic                   launch, issue, last_row, drain_end, row_neg;

   assign last_row  = (row == len_q - INDEX_WIDTH'(1));
   assign drain_end = (drain_cnt == 3'(RD_LATENCY - 1));
   // Full-width compare so neg_from = 2^ADDR_WIDTH never negates any row.
   assign row_neg   = neg_en_q && (row >= neg_from_q);

   always_ff @(posedge clk) begin
      if (!rst_n || !i_en) state <= IDLE;
      else                 state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      launch    = 1'b0;
      issue     = 1'b0;
      o_rd_en   = 4'h0;
      o_rd_addr = '0;
      o_busy    = (state != IDLE);
      o_done    = (state == IDLE);
      case (state)
         IDLE: begin
            if (i_start && (i_len != '0)) begin
               launch   = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            issue     = 1'b1;
            o_rd_en   = 4'hF;
            o_rd_addr = {4{row[ADDR_WIDTH-1:0]}};
            if (last_row) state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_end) state_nx = WAIT_DS;
         end
         WAIT_DS: begin
            if (i_ds_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !i_en) begin
         row        <= '0;
         len_q      <= '0;
         neg_from_q <= '0;
         neg_en_q   <= 1'b0;
         n_q        <= '0;
         drain_cnt  <= '0;
         vld_line   <= '0;
         neg_line   <= '0;
         start_q    <= 1'b0;
      end else begin
         start_q  <= launch;
         vld_line <= (vld_line << 1) | RD_LATENCY'(issue);
         neg_line <= (neg_line << 1) | RD_LATENCY'(issue && row_neg);
         if (launch) begin
            len_q      <= i_len;
            neg_from_q <= i_neg_from;
            neg_en_q   <= i_neg_en;
            n_q        <= i_n;
            row        <= '0;
            drain_cnt  <= '0;
         end
         if (issue)          row       <= row + INDEX_WIDTH'(1);
         if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      end
   end

   assign o_valid  = vld_line[RD_LATENCY-1];
   assign o_negate = neg_line[RD_LATENCY-1];
   assign o_data   = i_rd_data;
   assign o_n      = n_q;
   assign o_start  = start_q;

`ifdef MONOX_ROW_FEEDER_PERF_EN
   logic [31:0] cycles;

   always_ff @(posedge clk) begin
      if (!rst_n)                        cycles <= '0;
      else if (launch)                   cycles <= '0;
      else if (o_busy && (cycles != '1)) cycles <= cycles + 32'd1;
   end

   assign o_cycles = cycles;
`endif

endmodule

// File: tb/tb_monox_row_feeder.sv
// tb/tb_monox_row_feeder.sv - directed self-checking bench for monox_row_feeder
module tb_monox_row_feeder;
   localparam int DW  = 64;
   localparam int IW  = 13;
   localparam int AW  = 12;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n, i_en, i_start, i_neg_en, i_ds_done;
   logic [IW-1:0]     i_len, i_neg_from;
   logic [3:0]        i_n;
   logic [4*AW-1:0]   o_rd_addr;
   logic [3:0]        o_rd_en;
   logic [4*DW-1:0]   i_rd_data, o_data;
   logic              o_valid, o_negate, o_start, o_busy, o_done;
   logic [3:0]        o_n;
`ifdef MONOX_ROW_FEEDER_PERF_EN
   logic [31:0]       o_cycles;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   monox_row_feeder #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_start(i_start), .i_len(i_len),
      .i_neg_from(i_neg_from), .i_neg_en(i_neg_en), .i_n(i_n), .i_ds_done(i_ds_done),
      .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .i_rd_data(i_rd_data), .o_data(o_data),
      .o_valid(o_valid), .o_negate(o_negate), .o_n(o_n), .o_start(o_start),
      .o_busy(o_busy), .o_done(o_done)
`ifdef MONOX_ROW_FEEDER_PERF_EN
      , .o_cycles(o_cycles)
`endif
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle c counts clocks after the edge that sampled i_start; row r issues in cycle r+1.
   task automatic run(input int len, input int nf, input bit ne, input int ds,
                      input int restart, input int ncyc);
      logic [4*DW-1:0] pat;
      bit iss, vld, neg;
      @(negedge clk);
      i_len = IW'(len); i_neg_from = IW'(nf); i_neg_en = ne; i_n = 4'hA; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_n     = 4'h3;
      for (int c = 1; c <= ncyc; c++) begin
         pat = {4{64'(c) * 64'h0101_0101_0101_0101}};
         i_rd_data = pat;
         #1;
         iss = (c <= len);
         vld = (c >= 1 + LAT) && (c <= len + LAT);
         neg = vld && ne && ((c - 1 - LAT) >= nf);
         check("start", 256'(o_start), 256'(c == 1));
         check("rd_en", 256'(o_rd_en), 256'(iss ? 4'hF : 4'h0));
         if (iss) check("rd_addr", 256'(o_rd_addr), 256'({4{AW'(c - 1)}}));
         check("valid", 256'(o_valid), 256'(vld));
         check("negate", 256'(o_negate), 256'(neg));
         check("busy", 256'(o_busy), 256'(c <= ds));
         check("done", 256'(o_done), 256'(c > ds));
         check("o_n", 256'(o_n), 256'(4'hA));
         check("data", 256'(o_data), 256'(pat));
         i_start   = (c == restart);
         i_ds_done = (c >= ds);
         @(negedge clk);
      end
      i_ds_done = 1'b0;
      i_start   = 1'b0;
`ifdef MONOX_ROW_FEEDER_PERF_EN
      @(negedge clk);
      check("cycles", 256'(o_cycles), 256'(ds));
`endif
   endtask

   initial begin
      rst_n = 1'b0; i_en = 1'b1; i_start = 1'b0; i_len = '0; i_neg_from = '0;
      i_neg_en = 1'b0; i_n = 4'h0; i_ds_done = 1'b0; i_rd_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_done", 256'(o_done), 256'(1));
      check("rst_busy", 256'(o_busy), 256'(0));
      check("rst_valid", 256'(o_valid), 256'(0));
      check("rst_rd_en", 256'(o_rd_en), 256'(0));
      check("rst_addr", 256'(o_rd_addr), 256'(0));
      check("rst_start", 256'(o_start), 256'(0));
      check("rst_o_n", 256'(o_n), 256'(0));
`ifdef MONOX_ROW_FEEDER_PERF_EN
      check("rst_cycles", 256'(o_cycles), 256'(0));
`endif

      // zero length start is a no-op
      i_len = '0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("zl_start", 256'(o_start), 256'(0));
         check("zl_rd_en", 256'(o_rd_en), 256'(0));
         check("zl_done", 256'(o_done), 256'(1));
         check("zl_busy", 256'(o_busy), 256'(0));
         @(negedge clk);
      end

      run(4, 0, 1'b0, 10, 0, 12);
      run(8, 5, 1'b1, 11, 0, 13);
      run(8, 5, 1'b0, 12, 0, 14);
      run(6, 2, 1'b1, 10, 3, 12);
      run(4, 0, 1'b0, 8, 0, 11);

      // abort while row 2 of 6 is being issued
      @(negedge clk);
      i_len = IW'(6); i_neg_from = '0; i_neg_en = 1'b1; i_n = 4'h7; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ab_addr", 256'(o_rd_addr), 256'({4{AW'(2)}}));
      i_en = 1'b0;
      @(negedge clk);
      check("ab_valid", 256'(o_valid), 256'(0));
      check("ab_rd_en", 256'(o_rd_en), 256'(0));
      check("ab_done", 256'(o_done), 256'(1));
      check("ab_busy", 256'(o_busy), 256'(0));
      check("ab_o_n", 256'(o_n), 256'(0));
      i_en = 1'b1;
      @(negedge clk);
      check("ab_valid2", 256'(o_valid), 256'(0));
      check("ab_negate2", 256'(o_negate), 256'(0));
      run(3, 1, 1'b1, 7, 0, 9);

      run(4096, 4000, 1'b1, 4099, 0, 4102);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
